// File: rtl/mem_arbiter_if.sv
// Requester handshake and memory port bundle for mem_arbiter.
// slave = arbiter view; master = requesters plus memory.
interface mem_arbiter_if #(
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 19,
  parameter int MEM_ADDR_W = 19
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        lock;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_we;
  logic [MEM_ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, lock, mem_rdata,
    output gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, lock, mem_rdata,
    input  gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a single-port synchronous memory.
// Define MEM_ARB_LOCK_EN to let a locked requester keep top priority.
module mem_arbiter #(
  parameter int N_REQ      = 2,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 19,
  parameter int MEM_ADDR_W = 19
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_arbiter_if.slave    bus
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]      r_ptr;
  logic [PTR_W-1:0]      w_gnt_id;
  logic [PTR_W-1:0]      w_next_ptr;
  logic [N_REQ-1:0]      w_gnt;
  logic                  w_xfer;
  logic                  w_we;
  logic [ADDR_W-1:0]     w_addr;
  logic [DATA_W-1:0]     w_wdata;
  logic                  r_mem_we;
  logic [MEM_ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0]     r_mem_wdata;
  logic                  r_s1_v, r_s2_v;
  logic [PTR_W-1:0]      r_s1_id, r_s2_id;

  // First asserted request at or after r_ptr, wrapping modulo N_REQ.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx      = '0;
    w_gnt    = '0;
    w_gnt_id = '0;
    w_xfer   = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((32'(r_ptr) + k) % N_REQ);
      if (!w_xfer && bus.req[idx]) begin
        w_xfer     = 1'b1;
        w_gnt_id   = idx;
        w_gnt[idx] = 1'b1;
      end
    end
  end

  always_comb begin
    w_we    = bus.req_we[w_gnt_id];
    w_addr  = bus.req_addr[int'(w_gnt_id)*ADDR_W +: ADDR_W];
    w_wdata = bus.req_wdata[int'(w_gnt_id)*DATA_W +: DATA_W];
    w_next_ptr = (w_gnt_id == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
`ifdef MEM_ARB_LOCK_EN
    if (bus.lock[w_gnt_id]) begin
      w_next_ptr = w_gnt_id;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_s1_v      <= 1'b0;
      r_s1_id     <= '0;
      r_s2_v      <= 1'b0;
      r_s2_id     <= '0;
    end else begin
      r_s1_v  <= w_xfer & ~w_we;
      r_s1_id <= w_gnt_id;
      r_s2_v  <= r_s1_v;
      r_s2_id <= r_s1_id;
      if (w_xfer) begin
        r_mem_we    <= w_we;
        r_mem_addr  <= MEM_ADDR_W'(w_addr);
        r_mem_wdata <= w_wdata;
        r_ptr       <= w_next_ptr;
      end else begin
        r_mem_we <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.rvalid = '0;
    if (r_s2_v) begin
      bus.rvalid[r_s2_id] = 1'b1;
    end
  end

  assign bus.gnt       = w_gnt;
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized bench for mem_arbiter against a queue-based
// reference model with a 1K-word read-before-write memory.
module tb_mem_arbiter;
  localparam int N   = 2;
  localparam int AW  = 10;
  localparam int DW  = 19;
  localparam int MAW = 19;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MAW)) bus ();

  mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MAW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    bus.mem_rdata <= mem[bus.mem_addr[AW-1:0]];
    if (bus.mem_we) mem[bus.mem_addr[AW-1:0]] <= bus.mem_wdata;
  end

  typedef struct { int due; int id; int data; bit known; } rd_t;
  rd_t q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_g = -1;
  int m_ptr, m_addr, m_wd;
  bit m_we;
  int shadow [0:1023];
  bit sknown [0:1023];
  bit c_req [N];
  bit c_we [N];
  bit c_lock [N];
  int c_addr [N];
  int c_wd [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req[i]    = c_req[i];
      bus.req_we[i] = c_we[i];
      bus.lock[i]   = c_lock[i];
      bus.req_addr[i*AW +: AW]  = AW'(c_addr[i]);
      bus.req_wdata[i*DW +: DW] = DW'(c_wd[i]);
    end
  endtask

  task automatic cmd(input int i, input bit r, input bit we, input int a, input int d, input bit lk);
    c_req[i] = r; c_we[i] = we; c_addr[i] = a; c_wd[i] = d; c_lock[i] = lk;
    drive();
  endtask

  task automatic idle_all();
    for (int i = 0; i < N; i++) begin
      c_req[i] = 1'b0; c_lock[i] = 1'b0;
    end
    drive();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_addr = 0; m_wd = 0;
    q.delete();
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      if (c_req[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic tick();
    int g, a;
    rd_t e;
    @(negedge clk);
    g = pick();
    chk("gnt", 32'(bus.gnt), (g < 0) ? 32'd0 : (32'd1 << g));
    chk("mem_we", 32'(bus.mem_we), 32'(m_we));
    chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
    chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wd));
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rvalid", 32'(bus.rvalid), 32'd1 << e.id);
      if (e.known) chk("rdata", 32'(bus.rdata), 32'(e.data));
    end else begin
      chk("rvalid", 32'(bus.rvalid), 32'd0);
    end
    @(posedge clk);
    last_g = -1;
    if (rst_n) begin
      if (g >= 0) begin
        last_g = g;
        a = c_addr[g] % 1024;
        m_we = c_we[g]; m_addr = a; m_wd = c_wd[g];
        if (c_we[g]) begin
          shadow[a] = c_wd[g]; sknown[a] = 1'b1;
        end else begin
          q.push_back('{cyc + 2, g, shadow[a], sknown[a]});
        end
        m_ptr = (g + 1) % N;
`ifdef MEM_ARB_LOCK_EN
        if (c_lock[g]) m_ptr = g;
`endif
      end else begin
        m_we = 1'b0;
      end
    end
    cyc++;
    #1;
  endtask

  // Called just after a rising edge: drops reset mid-cycle and checks the
  // asynchronous clear before the next edge.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) sknown[i] = 1'b0;
    for (int i = 0; i < N; i++) begin
      c_req[i] = 0; c_we[i] = 0; c_lock[i] = 0; c_addr[i] = 0; c_wd[i] = 0;
    end
    drive();
    model_reset();
    #1;
    chk("init_mem_we", 32'(bus.mem_we), 32'd0);
    chk("init_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("init_rvalid", 32'(bus.rvalid), 32'd0);
    chk("init_gnt", 32'(bus.gnt), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;

`ifdef MEM_ARB_LOCK_EN
    cmd(0, 1, 0, 3, 0, 1);
    cmd(1, 1, 0, 4, 0, 0);
    tick(); chk("lock_g0", 32'(last_g), 32'd0);
    tick(); chk("lock_g1", 32'(last_g), 32'd0);
    tick(); chk("lock_g2", 32'(last_g), 32'd0);
    c_lock[0] = 1'b0; drive();
    tick(); chk("unlock_g0", 32'(last_g), 32'd0);
    tick(); chk("unlock_g1", 32'(last_g), 32'd1);
    idle_all();
    tick(); tick();
`endif

    // write then read back from requester 0
    cmd(0, 1, 1, 'h005, 'h7FFFF, 0);
    tick();
    cmd(0, 1, 0, 'h005, 0, 0);
    tick();
    idle_all();
    tick(); tick();

    // reset with a read sitting in the first pipeline stage
    cmd(0, 1, 0, 'h005, 0, 0);
    tick();
    cmd(0, 1, 0, 'h005, 0, 0);
    cmd(1, 1, 0, 'h005, 0, 0);
    async_reset();
    tick();
    chk("post_rst_grant", 32'(last_g), 32'd0);
    tick(); tick(); tick();
    idle_all();
    tick(); tick();

    // write from 1 then immediate read of the same word from 0
    cmd(1, 1, 1, 'h3FF, 'h12345, 0);
    tick();
    c_req[1] = 1'b0;
    cmd(0, 1, 0, 'h3FF, 0, 0);
    tick();
    idle_all();
    tick(); tick();

    // idle: mem_addr must hold its last value
    for (int n = 0; n < 5; n++) tick();

    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!c_req[i] || last_g == i) begin
          c_req[i]  = ($urandom_range(0, 3) != 0);
          c_we[i]   = 1'($urandom_range(0, 1));
          c_addr[i] = ($urandom_range(0, 1) != 0 ? 1016 : 0) + int'($urandom_range(0, 7));
          c_wd[i]   = int'($urandom_range(0, (1 << DW) - 1));
          c_lock[i] = 1'($urandom_range(0, 1));
        end
      end
      drive();
      tick();
    end
    idle_all();
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
